// File: rtl/cpu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encodings and
// default timing parameters, reused by the fetch and d_mem wrappers.
package cpu_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int EX_CYCLES_DEF   = 1;
    localparam int MEM_TIMEOUT_DEF = 8;
    localparam int CNT_W_DEF       = 16;

    // Counter widths sized to the legal parameter ranges (1..15 and 1..255).
    localparam int EX_CNT_W  = 4;
    localparam int MEM_CNT_W = 8;

endpackage

// File: rtl/cpu_seq_ctrl_wait_cnt.sv
// Loadable down-counter with zero flag; used for EXECUTE dwell time and for
// the FETCH/MEMORY ready timeout.
module seq_wait_cnt
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int W = MEM_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH..WRITEBACK and
// drives PC-advance, IR-load, register-write and data-memory strobes.
module cpu_seq_ctrl
    import cpu_seq_ctrl_pkg::*;
#(
    parameter int EX_CYCLES   = EX_CYCLES_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             reg_wr_req,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             reg_wr_en,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [EX_CNT_W-1:0]  EX_LOAD = EX_CNT_W'(EX_CYCLES - 1);
    localparam logic [MEM_CNT_W-1:0] TO_LOAD = MEM_CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic             ex_load, ex_dec, ex_zero;
    logic             to_load, to_dec, to_zero;

    seq_wait_cnt #(.W(EX_CNT_W)) u_ex_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ex_load),
        .load_val (EX_LOAD),
        .dec      (ex_dec),
        .zero     (ex_zero)
    );

    seq_wait_cnt #(.W(MEM_CNT_W)) u_to_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (to_load),
        .load_val (TO_LOAD),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    always_comb begin
        state_d = state_q;
        ex_load = 1'b0;
        ex_dec  = 1'b0;
        to_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE:      if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                // Ready is checked before the timeout so a late ready still wins.
                if (imem_ready)   state_d = ST_DECODE;
                else if (to_zero) state_d = ST_FAULT;
                else              to_dec  = 1'b1;
            end
            ST_DECODE: begin
                ex_load = 1'b1;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (!ex_zero)                   ex_dec  = 1'b1;
                else if (is_load ^ is_store)    state_d = ST_MEMORY;
                else if (is_load && is_store)   state_d = ST_FAULT;
                else                            state_d = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (dmem_ready)   state_d = ST_WRITEBACK;
                else if (to_zero) state_d = ST_FAULT;
                else              to_dec  = 1'b1;
            end
            ST_WRITEBACK: state_d = halt ? ST_IDLE : ST_FETCH;
            ST_FAULT:     state_d = ST_FAULT;
            default:      state_d = ST_FAULT;
        endcase
        // Timeout window restarts on every entry into a wait state.
        to_load = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEMORY));
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (state_q == ST_WRITEBACK) instr_count_d = instr_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign imem_req    = (state_q == ST_FETCH);
    assign ir_load     = (state_q == ST_FETCH) && imem_ready;
    assign pc_en       = (state_q == ST_WRITEBACK);
    assign reg_wr_en   = (state_q == ST_WRITEBACK) && reg_wr_req && !is_store;
    assign dmem_rd     = (state_q == ST_MEMORY) && is_load;
    assign dmem_wr     = (state_q == ST_MEMORY) && is_store;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign fault       = (state_q == ST_FAULT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus pushes expected WRITEBACK
// responses, an independent monitor pops and checks them on every pc_en.
module tb_cpu_seq_ctrl;
    import cpu_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, run, halt, imem_ready, dmem_ready, is_load, is_store, reg_wr_req;
    logic        imem_req, ir_load, pc_en, dmem_rd, dmem_wr, reg_wr_en, busy, fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    cpu_seq_ctrl #(.EX_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .halt        (halt),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .is_load     (is_load),
        .is_store    (is_store),
        .reg_wr_req  (reg_wr_req),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .pc_en       (pc_en),
        .dmem_rd     (dmem_rd),
        .dmem_wr     (dmem_wr),
        .reg_wr_en   (reg_wr_en),
        .busy        (busy),
        .fault       (fault),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reg_wr_en;
        logic [15:0] count_before;
        int          latency;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pc_total = 0;
    int   imem_total = 0;
    int   rd_total = 0;
    int   wr_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    // Monitor: samples on the falling edge, counts strobes and checks each WRITEBACK.
    initial begin
        logic [2:0] prev;
        int         cyc;
        exp_t       e;
        prev = 3'd0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            if (state == 3'd1 && prev != 3'd1) cyc = 1;
            else if (cyc != 0)                 cyc++;
            prev = state;
            if (imem_req) imem_total++;
            if (dmem_rd)  rd_total++;
            if (dmem_wr)  wr_total++;
            if (pc_en) begin
                pc_total++;
                if (sb.size() == 0) begin
                    check("unexpected_pc_en", {31'd0, pc_en}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wb_reg_wr_en", {31'd0, reg_wr_en}, {31'd0, e.reg_wr_en});
                    check("wb_count_before", {16'd0, instr_count}, {16'd0, e.count_before});
                    check("wb_latency", cyc, e.latency);
                    check("wb_state", {29'd0, state}, 32'd5);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pc, base_rd, base_wr, base_im;

        rst = 1'b1; run = 1'b0; halt = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
        is_load = 1'b0; is_store = 1'b0; reg_wr_req = 1'b1;
        step(2);
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_strobes", {26'd0, imem_req, ir_load, pc_en, dmem_rd, dmem_wr, reg_wr_en}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_hold", {29'd0, state}, 32'd0);

        // ALU op, single instruction then halt
        base_pc = pc_total;
        sb.push_back('{1'b1, 16'd0, 4});
        pulse_run();
        check("alu_s1", {29'd0, state}, 32'd1);
        step(); check("alu_s2", {29'd0, state}, 32'd2);
        step(); check("alu_s3", {29'd0, state}, 32'd3);
        step(); check("alu_s5", {29'd0, state}, 32'd5);
        check("alu_pc_regwr", {30'd0, pc_en, reg_wr_en}, 32'd3);
        step(); check("alu_idle", {29'd0, state}, 32'd0);
        check("alu_count", {16'd0, instr_count}, 32'd1);
        check("alu_pc_once", pc_total - base_pc, 32'd1);

        // sw with dmem_ready delayed 3 cycles
        is_store = 1'b1;
        base_rd = rd_total; base_wr = wr_total; base_pc = pc_total;
        sb.push_back('{1'b0, 16'd1, 8});
        pulse_run();
        step(3);
        check("sw_mem", {29'd0, state}, 32'd4);
        check("sw_wr_on", {30'd0, dmem_rd, dmem_wr}, 32'd1);
        step(3);
        check("sw_mem_wait", {29'd0, state}, 32'd4);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("sw_wb", {29'd0, state}, 32'd5);
        check("sw_regwr_off", {31'd0, reg_wr_en}, 32'd0);
        step();
        check("sw_wr_cycles", wr_total - base_wr, 32'd4);
        check("sw_rd_cycles", rd_total - base_rd, 32'd0);
        check("sw_pc_once", pc_total - base_pc, 32'd1);
        check("sw_count", {16'd0, instr_count}, 32'd2);

        // lw with immediate dmem_ready (ready held high outside MEMORY too)
        is_store = 1'b0; is_load = 1'b1; dmem_ready = 1'b1;
        base_rd = rd_total;
        sb.push_back('{1'b1, 16'd2, 5});
        pulse_run();
        step(3);
        check("lw_rd_on", {29'd0, state, dmem_rd}, 32'h9);
        step(); check("lw_wb", {29'd0, state}, 32'd5);
        step();
        dmem_ready = 1'b0;
        check("lw_rd_cycles", rd_total - base_rd, 32'd1);
        check("lw_count", {16'd0, instr_count}, 32'd3);

        // imem_ready on the last timeout cycle: ready wins
        is_load = 1'b0; imem_ready = 1'b0;
        sb.push_back('{1'b1, 16'd3, 11});
        pulse_run();
        step(7);
        check("late_fetch8", {29'd0, state}, 32'd1);
        check("late_irload_off", {31'd0, ir_load}, 32'd0);
        imem_ready = 1'b1;
        #1;
        check("late_irload_on", {31'd0, ir_load}, 32'd1);
        step(); check("late_decode", {29'd0, state}, 32'd2);
        step(3);
        check("late_count", {16'd0, instr_count}, 32'd4);

        // lw with imem_ready never asserted -> FAULT after 8 FETCH cycles
        is_load = 1'b1; imem_ready = 1'b0;
        base_pc = pc_total;
        pulse_run();
        step(7);
        check("to_fetch8", {29'd0, state}, 32'd1);
        step();
        check("to_fault", {29'd0, state}, 32'd6);
        check("to_flags", {30'd0, fault, busy}, 32'd2);
        run = 1'b1;
        step(3);
        run = 1'b0;
        check("to_sticky", {29'd0, state, imem_req}, 32'hC);
        check("to_no_pc", pc_total - base_pc, 32'd0);
        rst = 1'b1; #1;
        check("to_rst_clears", {30'd0, fault, busy}, 32'd0);
        step(); rst = 1'b0; step();

        // is_load and is_store both set -> FAULT without any data strobe
        is_load = 1'b1; is_store = 1'b1; imem_ready = 1'b1;
        base_rd = rd_total; base_wr = wr_total;
        pulse_run();
        step(3);
        check("both_fault", {29'd0, state}, 32'd6);
        check("both_no_dmem", (rd_total - base_rd) + (wr_total - base_wr), 32'd0);
        rst = 1'b1; step(); rst = 1'b0; step();

        // three back-to-back ALU ops, halt during the third WRITEBACK
        is_load = 1'b0; is_store = 1'b0; halt = 1'b0;
        base_im = imem_total;
        sb.push_back('{1'b1, 16'd0, 4});
        sb.push_back('{1'b1, 16'd1, 4});
        sb.push_back('{1'b1, 16'd2, 4});
        pulse_run();
        step(11);
        check("b2b_wb3", {29'd0, state}, 32'd5);
        halt = 1'b1;
        step();
        check("b2b_idle", {29'd0, state}, 32'd0);
        check("b2b_count", {16'd0, instr_count}, 32'd3);
        step(4);
        check("b2b_imem_cycles", imem_total - base_im, 32'd3);
        check("b2b_still_idle", {29'd0, state, imem_req}, 32'd0);

        // reset mid-MEMORY while dmem_wr is high
        is_store = 1'b1; dmem_ready = 1'b0;
        pulse_run();
        step(3);
        check("rstm_wr_on", {28'd0, state, dmem_wr}, 32'h9);
        #2 rst = 1'b1;
        #1;
        check("rstm_wr_off", {31'd0, dmem_wr}, 32'd0);
        check("rstm_state", {29'd0, state}, 32'd0);
        check("rstm_count", {16'd0, instr_count}, 32'd0);
        step(); rst = 1'b0; step();

        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
